nes_pad_responder: RTL
======================

// Module: nes_pad_responder
// PURPOSE
//  Device-side NES controller emulator: answers a host's latch/clock strobes by shifting
//  out 8 button bits on the serial data line, exactly as a 4021-based pad does.
//  Sits between a virtual button source (keyboard/UART/test stimulus) and a NES-style
//  host reader, so the host can be driven without a physical pad.
// PARAMETERS
//  SYNC_STAGES     2        flops in each latch/clock input synchronizer (>=2)
//  TIMEOUT_CYCLES  1<<20    clk cycles without a latch rise before host_active drops
//  TAIL_LEVEL      1'b0     data_out level after 8 bits (official pad: 0 = reads "pressed")
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst_n       in   1  reset, asynchronous, active-low
//  latch_in    in   1  host latch strobe, async to clk, active-high
//  clock_in    in   1  host serial clock, async to clk; idle low, pulses high per bit
//  buttons_in  in   8  active-high presses: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right
//  data_out    out  1  serial data to host, active-low (0 = pressed)
//  frame_done  out  1  1-cycle pulse when the 8th bit has been shifted past
//  overrun     out  1  sticky: >8 clock falls in one frame; cleared by next latch rise
//  host_active out  1  1 while latch rises arrive within TIMEOUT_CYCLES of each other
// BEHAVIOUR
//  Reset: data_out=1, frame_done=0, overrun=0, host_active=0, state=IDLE, shreg=8'hFF, bitcnt=0.
//  Inputs pass through SYNC_STAGES-flop synchronizer, then 1-flop edge detect; all action
//   on synced edges -> data_out changes SYNC_STAGES+1 clk after the async input edge.
//  shreg[7:0] holds line levels; data_out = (bitcnt==8) ? TAIL_LEVEL : shreg[7].
//  States:
//   IDLE  : data_out=shreg[7]; latch rise -> LOAD.
//   LOAD  : every cycle shreg <= ~buttons_in (transparent parallel load), bitcnt=0;
//           latch fall -> SHIFT (value frozen at the last high cycle). data_out = ~A.
//   SHIFT : each clock_in fall: shreg <= {shreg[6:0],1'b1}, bitcnt++ (saturates at 8);
//           on transition bitcnt 7->8 pulse frame_done, -> DONE.
//   DONE  : data_out=TAIL_LEVEL; further clock falls set overrun; latch rise -> LOAD.
//  Clock rises are ignored (host samples on rise; we shift on fall -> bit stable on sample).
//  Latch rise in any state -> LOAD immediately, aborts a partial frame, no frame_done,
//   clears overrun. Clock fall while latch high is ignored (LOAD wins).
//  Simultaneous synced latch fall + clock fall: take latch fall only (no shift).
//  Watchdog: counter reset to 0 and host_active<=1 on each latch rise; if it reaches
//   TIMEOUT_CYCLES-1, host_active<=0 and counter holds (no wrap).
//  buttons_in change during SHIFT/DONE has no effect until next LOAD.
//  rst_n assertion mid-frame: immediate return to reset values; data_out=1 until a latch.
// STRUCTURE
//  Package nes_pad_pkg: state enum (IDLE,LOAD,SHIFT,DONE), button bit-index constants
//   (BTN_A=7..BTN_RIGHT=0), NES_BITS=8; shared with the host-side reader.
//  Sub-module nes_sync_edge (#(SYNC_STAGES)): synchronizer + rise/fall pulse outputs;
//   instantiated twice (latch, clock). Counters/FSM in this module.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> data_out=1, frame_done=0, overrun=0, host_active=0 at once.
//  2 buttons_in=8'b1000_1001, latch then 8 clocks (256-clk phases) -> host samples on clock
//    rise 0,1,1,1,0,1,1,0; frame_done pulses once after 8th fall; data_out=TAIL_LEVEL.
//  3 Latch during bit 4 -> reload, sequence restarts at bit A, no frame_done, overrun=0.
//  4 10 clock pulses after latch -> bits 9,10 read TAIL_LEVEL; overrun=1 until next latch.
//  5 buttons_in toggled while latch high then held after fall -> value at latch fall is sent.
//  6 No latch for TIMEOUT_CYCLES (set 64 in bench) -> host_active 1->0; next latch -> 1.

Source files
------------

// File: rtl/nes_pad_pkg.sv
// Shared NES pad definitions: FSM states, button bit positions and frame length.
// The host-side reader uses the same button indices.
package nes_pad_pkg;

   localparam int NES_BITS = 8;
   localparam int CNT_W    = $clog2(NES_BITS + 1);

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } pad_state_t;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } strobe_t;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for one asynchronous host strobe, followed by a
// one-flop edge detector giving single-cycle rise/fall pulses.
module nes_sync_edge
   import nes_pad_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    din,
   output strobe_t strobe
);

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   prev;

   // Strobes idle low, so reset to 0: a line held high through reset
   // produces a rise right after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_pipe <= '0;
         prev      <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
         prev      <= sync_pipe[SYNC_STAGES-1];
      end
   end

   assign strobe.level = sync_pipe[SYNC_STAGES-1];
   assign strobe.rise  = sync_pipe[SYNC_STAGES-1] & ~prev;
   assign strobe.fall  = ~sync_pipe[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/nes_pad_responder.sv
// Device-side NES pad emulator: answers host latch/clock strobes by shifting
// out the 8 button bits active-low, like a 4021-based controller.
module nes_pad_responder
   import nes_pad_pkg::*;
#(
   parameter int          SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
   parameter logic        TAIL_LEVEL     = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                latch_in,
   input  logic                clock_in,
   input  logic [NES_BITS-1:0] buttons_in,
   output logic                data_out,
   output logic                frame_done,
   output logic                overrun,
   output logic                host_active
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NES_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NES_BITS);

   strobe_t latch_s;
   strobe_t clock_s;

   pad_state_t          state;
   logic [NES_BITS-1:0] shreg;
   logic [CNT_W-1:0]    bitcnt;
   logic [WD_W-1:0]     wd_cnt;

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (latch_in),
      .strobe (latch_s)
   );

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clock_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (clock_in),
      .strobe (clock_s)
   );

   // A latch rise overrides everything: it aborts any partial frame and
   // restarts the parallel load without a frame_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '1;
         bitcnt     <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (latch_s.rise) begin
            state   <= LOAD;
            shreg   <= ~buttons_in;
            bitcnt  <= '0;
            overrun <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               LOAD: begin
                  // The fall cycle does not reload, so the value from the
                  // last synced-high cycle is the one sent.
                  if (latch_s.fall) begin
                     state <= SHIFT;
                  end else begin
                     shreg  <= ~buttons_in;
                     bitcnt <= '0;
                  end
               end
               SHIFT: begin
                  if (clock_s.fall) begin
                     shreg <= {shreg[NES_BITS-2:0], 1'b1};
                     if (bitcnt == CNT_LAST) begin
                        bitcnt     <= CNT_FULL;
                        frame_done <= 1'b1;
                        state      <= DONE;
                     end else begin
                        bitcnt <= bitcnt + 1'b1;
                     end
                  end
               end
               DONE: begin
                  if (clock_s.fall) overrun <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Watchdog saturates at its last value rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         host_active <= 1'b0;
      end else if (latch_s.rise) begin
         wd_cnt      <= '0;
         host_active <= 1'b1;
      end else if (wd_cnt == WD_LAST) begin
         host_active <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign data_out = (bitcnt == CNT_FULL) ? TAIL_LEVEL : shreg[NES_BITS-1];

endmodule
